echo_delay_line: RTL and testbench
==================================

// Module: echo_delay_line
// PURPOSE
//   Parametrised circular-buffer delay line for the pedal sample path, writing and reading one
//   memory per sample beat. Each valid input sample is stored; the sample from 'delay' beats
//   earlier is read back. Output is either the pure delayed sample or a saturated echo mix
//   (dry + attenuated delayed). Sits between the sample source and the processing/output memory.
// PARAMETERS
//   DATA_W     8  sample width, two's-complement signed
//   ADDR_W     4  buffer address width; DEPTH = 2**ADDR_W entries, max delay DEPTH-1 beats
//   MIX_SHIFT  1  echo attenuation: delayed term is arithmetically shifted right by MIX_SHIFT
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       one sample beat this cycle; no backpressure
//   in_data    in   DATA_W  signed input sample
//   delay      in   ADDR_W  delay in beats, 0..DEPTH-1; sampled on each beat
//   mode       in   1       0 = pure delay, 1 = echo mix; sampled on each beat
//   out_valid  out  1       registered; high exactly 1 cycle after each in_valid
//   out_data   out  DATA_W  signed result; holds its value between beats
//   primed     out  1       registered; 1 when fill >= delay, i.e. delayed tap holds real data
// BEHAVIOUR
//   - Reset (async, immediate):
//     - wr_ptr = 0, fill = 0, out_valid = 0, out_data = 0, primed = 0.
//     - Memory contents are NOT cleared; stale entries are masked by fill.
//   - fill: count of beats written since reset, saturating at DEPTH-1.
//   - On a beat (in_valid = 1), with fill and wr_ptr at their pre-beat values:
//     - tap:
//       - delay == 0: tap = in_data (bypass, no memory read).
//       - else if delay > fill: tap = 0 (warm-up).
//       - else: tap = mem[(wr_ptr - delay) mod DEPTH], read before this beat's write.
//     - mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr + 1, wrapping DEPTH-1 -> 0.
//     - fill <= min(fill + 1, DEPTH-1).
//     - out_data <= (mode == 0) ? tap : sat(in_data + (tap >>> MIX_SHIFT)).
//       - Sum is computed at DATA_W+1 bits.
//       - Clip to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
//     - out_valid <= 1; primed <= (delay <= fill) | (delay == 0).
//   - No beat: out_valid <= 0; out_data, primed, wr_ptr and fill hold.
//   - Latency: 1 clock from in_valid to out_valid.
//   - Delay counts beats, not cycles: idle gaps between beats do not age samples.
//   - delay or mode changes take effect on the beat where they are sampled; no glitch or
//     cross-fade, and no other beats are affected.
//   - Reset mid-stream:
//     - Outputs drop asynchronously.
//     - The next beat after release is treated as sample 0 (warm-up zeros again).
//   - Memory: DEPTH x DATA_W register array; single write port, one read port.
// TESTING  (DATA_W=8, ADDR_W=4, MIX_SHIFT=1)
//   1 Warm-up: rst, then ramp 1,2,3,... on consecutive beats, delay=3, mode=0
//     -> out_data 0,0,0,1,2,3,...; primed 0,0,0,1,...; each out_valid 1 cycle after in_valid.
//   2 Bypass: delay=0, mode=0, random samples -> out_data == in_data one cycle later;
//     primed=1 from the first beat.
//   3 Wrap: 40 ramp beats, delay=15 -> from beat 15 on, out[n] = in[n-15];
//     no discontinuity where wr_ptr wraps 15 -> 0 (beats 16, 32).
//   4 Echo saturation: mode=1, delay=1, in = 100 constant -> outputs 100, then 127 (clipped);
//     in = -128 constant -> -128, then -128; in = 20 constant -> 20, then 30.
//   5 Gaps: beats with 0-3 idle cycles between them, delay=2 -> output equals the sample
//     from 2 beats earlier; out_valid never high without a preceding beat.
//   6 Reset mid-stream: 10 beats of 0x55, delay=3, then assert rst mid-cycle
//     -> out_valid, out_data, primed = 0 immediately; after release the first 3 outputs are
//     0 (stale 0x55 masked), then the new data follows.

Source files
------------

// File: rtl/echo_delay_line_if.sv
// rtl/echo_delay_line_if.sv - sample-beat bundle between the sample source and the delay line
interface echo_delay_line_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0]        delay;
  logic                     mode;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     primed;

  modport master (
    output in_valid, in_data, delay, mode,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  in_valid, in_data, delay, mode,
    output out_valid, out_data, primed
  );
endinterface

// File: rtl/echo_delay_line.sv
// rtl/echo_delay_line.sv - circular-buffer delay line with optional saturated echo mix
module echo_delay_line #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int MIX_SHIFT = 1
) (
  input logic               clk,
  input logic               rst,
  echo_delay_line_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]        FILL_MAX = '1;
  localparam logic signed [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        fill;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     primed_q;

  logic [ADDR_W-1:0]        rd_addr;
  logic                     bypass;
  logic                     warm_up;
  logic signed [DATA_W-1:0] tap;
  logic signed [DATA_W-1:0] tap_att;
  logic signed [DATA_W:0]   mix_sum;
  logic signed [DATA_W-1:0] mix_sat;
  logic signed [DATA_W-1:0] result;
  logic [ADDR_W-1:0]        fill_next;

  // Pointer arithmetic wraps naturally at ADDR_W bits, giving the mod-DEPTH read address.
  assign rd_addr = wr_ptr - bus.delay;
  assign bypass  = (bus.delay == '0);
  assign warm_up = (bus.delay > fill);

  always_comb begin
    tap = '0;
    if (bypass)
      tap = bus.in_data;
    else if (!warm_up)
      tap = mem[rd_addr];
  end

  assign tap_att = tap >>> MIX_SHIFT;
  assign mix_sum = {bus.in_data[DATA_W-1], bus.in_data} + {tap_att[DATA_W-1], tap_att};

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    mix_sat = mix_sum[DATA_W-1:0];
    if (mix_sum[DATA_W] != mix_sum[DATA_W-1])
      mix_sat = mix_sum[DATA_W] ? SAT_MIN : SAT_MAX;
  end

  assign result    = bus.mode ? mix_sat : tap;
  assign fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;

  always_ff @(posedge clk) begin
    if (bus.in_valid && !rst)
      mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else if (bus.in_valid) begin
      wr_ptr      <= wr_ptr + 1'b1;
      fill        <= fill_next;
      out_valid_q <= 1'b1;
      out_data_q  <= result;
      primed_q    <= !warm_up || bypass;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.primed    = primed_q;
endmodule

// File: tb/tb_echo_delay_line.sv
// tb/tb_echo_delay_line.sv - scoreboard bench for echo_delay_line
module tb_echo_delay_line;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  echo_delay_line_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  echo_delay_line #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MIX_SHIFT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       primed;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference keeps every sample since reset in a linear history, no ring buffer.
  function automatic exp_t model_beat(int din, int dly, bit md);
    int   fill, tap, s;
    exp_t e;
    fill = (hist.size() > DEPTH-1) ? DEPTH-1 : hist.size();
    if (dly == 0)        tap = din;
    else if (dly > fill) tap = 0;
    else                 tap = hist[hist.size()-dly];
    if (!md) s = tap;
    else begin
      s = din + (tap >>> 1);
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
    end
    e.data   = 8'(s);
    e.primed = (dly <= fill) || (dly == 0);
    hist.push_back(din);
    return e;
  endfunction

  task automatic send_beat(int din, int dly, bit md);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(din);
    bus.delay    = 4'(dly);
    bus.mode     = md;
    sb.push_back(model_beat(din, dly, md));
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.primed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%0d p=%b, want v=0 d=0 p=0",
               bus.out_valid, bus.out_data, bus.primed);
    end
    @(negedge clk);
    rst = 1'b0;
    go_idle();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%b d=%0d, want v=0 d=0", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_warmup();
    exp_t e;
    int   want;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      send_beat(n + 1, 3, 1'b0);
      e = sb.pop_front();
      want = (n < 3) ? 0 : n - 2;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.primed !== e.primed) begin
        n_fail++;
        $display("FAIL warmup_sb beat %0d: got v=%b d=%0d p=%b, want v=1 d=%0d p=%b",
                 n, bus.out_valid, bus.out_data, bus.primed, $signed(e.data), e.primed);
      end
      n_checks++;
      if (bus.out_data !== 8'(want) || bus.primed !== (n >= 3)) begin
        n_fail++;
        $display("FAIL warmup_ramp beat %0d: got d=%0d p=%b, want d=%0d p=%b",
                 n, bus.out_data, bus.primed, want, (n >= 3));
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    int   din;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      din = int'($urandom_range(0, 255)) - 128;
      send_beat(din, 0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(din) || bus.primed !== 1'b1 ||
          bus.out_data !== e.data) begin
        n_fail++;
        $display("FAIL bypass beat %0d: got v=%b d=%0d p=%b, want v=1 d=%0d p=1",
                 n, bus.out_valid, bus.out_data, bus.primed, din);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      send_beat(n + 1, 15, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.primed !== e.primed) begin
        n_fail++;
        $display("FAIL wrap_sb beat %0d: got v=%b d=%0d p=%b, want v=1 d=%0d p=%b",
                 n, bus.out_valid, bus.out_data, bus.primed, $signed(e.data), e.primed);
      end
      if (n >= 15) begin
        n_checks++;
        if (bus.out_data !== 8'(n - 14)) begin
          n_fail++;
          $display("FAIL wrap_tap beat %0d: got d=%0d, want d=%0d", n, bus.out_data, n - 14);
        end
      end
    end
  endtask

  task automatic test_echo_saturation();
    exp_t e;
    int   ins  [3] = '{100, -128, 20};
    int   want [3][2] = '{'{100, 127}, '{-128, -128}, '{20, 30}};
    for (int g = 0; g < 3; g++) begin
      do_reset();
      for (int k = 0; k < 2; k++) begin
        send_beat(ins[g], 1, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(want[g][k]) ||
            bus.out_data !== e.data) begin
          n_fail++;
          $display("FAIL echo_sat in=%0d beat %0d: got v=%b d=%0d, want v=1 d=%0d",
                   ins[g], k, bus.out_valid, bus.out_data, want[g][k]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    exp_t e;
    int   gap;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      send_beat(int'($urandom_range(0, 255)) - 128, 2, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.primed !== e.primed) begin
        n_fail++;
        $display("FAIL gaps beat %0d: got v=%b d=%0d p=%b, want v=1 d=%0d p=%b",
                 n, bus.out_valid, bus.out_data, bus.primed, $signed(e.data), e.primed);
      end
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++) begin
        go_idle();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== e.data || bus.primed !== e.primed) begin
          n_fail++;
          $display("FAIL gaps_idle after beat %0d: got v=%b d=%0d p=%b, want v=0 d=%0d p=%b",
                   n, bus.out_valid, bus.out_data, bus.primed, $signed(e.data), e.primed);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)));
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.primed !== e.primed) begin
        n_fail++;
        $display("FAIL back_to_back beat %0d: got v=%b d=%0d p=%b, want v=1 d=%0d p=%b",
                 n, bus.out_valid, bus.out_data, bus.primed, $signed(e.data), e.primed);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      send_beat(8'h55, 3, 1'b0);
      e = sb.pop_front();
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.primed !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got v=%b d=%0d p=%b, want v=0 d=0 p=0",
               bus.out_valid, bus.out_data, bus.primed);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    sb.delete();
    for (int n = 0; n < 6; n++) begin
      send_beat(n + 1, 3, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'((n < 3) ? 0 : n - 2) ||
          bus.primed !== (n >= 3) || bus.out_data !== e.data) begin
        n_fail++;
        $display("FAIL mid_reset_refill beat %0d: got v=%b d=%0d p=%b, want v=1 d=%0d p=%b",
                 n, bus.out_valid, bus.out_data, bus.primed, (n < 3) ? 0 : n - 2, (n >= 3));
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.delay    = '0;
    bus.mode     = 1'b0;
    test_reset();
    test_warmup();
    test_bypass();
    test_wrap();
    test_echo_saturation();
    test_gaps();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
